// File: rtl/loop_activity_monitor.sv
// -----------------------------------------------------------------------------
// loop_activity_monitor
//
// Passive performance monitor for one HLS block. It observes the block-level
// ap_* handshake and one pipelined loop (FSM state, stage block flags, stage
// enables, loop handshake) and keeps run / iteration / stall / latency counters
// plus one-cycle event strobes. It never drives the monitored design.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   finish                freezes all state (sticky frozen flag until reset)
//   ap_start/ready/done/continue   module handshake
//   cur_state, *_state    loop FSM current state and one-hot state constants
//   *_block, *_enable     stage subdone block flags and pipeline stage enables
//   loop_start/ready/done/continue loop handshake
//   quit_at_end           where loop exit is evaluated (informational here)
//   mod_*                 module busy flag, run/ready counts, last latency
//   loop_*, iter_*        loop active flag, run count, trip counts, strobes
//   stall_cycles          cycles stalled in the iteration-start state
//   frozen                finish has been seen
// All counters saturate at all-ones.
// -----------------------------------------------------------------------------
module loop_activity_monitor #(
    parameter int STATE_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               finish,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_run_count,
    output logic [CNT_W-1:0]   mod_ready_count,
    output logic [CNT_W-1:0]   mod_last_latency,
    output logic               loop_active,
    output logic [CNT_W-1:0]   loop_run_count,
    output logic [CNT_W-1:0]   loop_last_trip,
    output logic               iter_start_pulse,
    output logic               iter_end_pulse,
    output logic               quit_pulse,
    output logic [CNT_W-1:0]   iter_total,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               frozen
);

    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_WAIT_CONT} mod_state_e;
    typedef enum logic [1:0] {L_IDLE, L_RUN, L_WAIT_CONT} loop_state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    mod_state_e       mod_state_q, mod_state_d;
    loop_state_e      loop_state_q, loop_state_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] mod_run_q, mod_run_d;
    logic [CNT_W-1:0] mod_ready_q, mod_ready_d;
    logic [CNT_W-1:0] mod_lat_q, mod_lat_d;
    logic [CNT_W-1:0] trip_q, trip_d;
    logic [CNT_W-1:0] loop_run_q, loop_run_d;
    logic [CNT_W-1:0] last_trip_q, last_trip_d;
    logic [CNT_W-1:0] iter_total_q, iter_total_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             start_pulse_q, start_pulse_d;
    logic             end_pulse_q, end_pulse_d;
    logic             quit_pulse_q, quit_pulse_d;
    logic             frozen_q, frozen_d;

    logic             in_run;
    logic             iter_start_evt, iter_end_evt, quit_evt, stall_evt;
    logic             freeze;
    logic [CNT_W-1:0] trip_inc;

    // Only iter_end_evt credits iterations, so the quit stage position and the
    // loop ready strobe do not change any counter; they are observed only.
    logic unused_inputs;
    assign unused_inputs = ^{quit_at_end, loop_ready};

    assign in_run         = (loop_state_q == L_RUN);
    assign iter_start_evt = in_run & (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
    assign iter_end_evt   = in_run & (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
    assign quit_evt       = in_run & (cur_state == quit_state) & ~quit_block & quit_enable;
    assign stall_evt      = in_run & (cur_state == iter_start_state) & iter_start_block;

    // finish takes effect on the very edge where it is sampled.
    assign freeze   = finish | frozen_q;
    assign trip_inc = iter_end_evt ? sat_inc(trip_q) : trip_q;

    always_comb begin
        // NOTE: every *_d gets a hold default first so no path infers a latch.
        mod_state_d   = mod_state_q;
        loop_state_d  = loop_state_q;
        lat_d         = lat_q;
        mod_run_d     = mod_run_q;
        mod_ready_d   = mod_ready_q;
        mod_lat_d     = mod_lat_q;
        trip_d        = trip_q;
        loop_run_d    = loop_run_q;
        last_trip_d   = last_trip_q;
        iter_total_d  = iter_total_q;
        stall_d       = stall_q;
        start_pulse_d = 1'b0;
        end_pulse_d   = 1'b0;
        quit_pulse_d  = 1'b0;
        frozen_d      = frozen_q | finish;

        if (!freeze) begin
            start_pulse_d = iter_start_evt;
            end_pulse_d   = iter_end_evt;
            quit_pulse_d  = quit_evt;

            if (ap_ready) mod_ready_d = sat_inc(mod_ready_q);

            unique case (mod_state_q)
                M_IDLE: begin
                    if (ap_start) begin
                        lat_d = ONE;
                        if (ap_done) begin
                            // Zero-length run: start and done together.
                            mod_lat_d   = ONE;
                            mod_run_d   = sat_inc(mod_run_q);
                            mod_state_d = ap_continue ? M_IDLE : M_WAIT_CONT;
                        end else begin
                            mod_state_d = M_BUSY;
                        end
                    end
                end
                M_BUSY: begin
                    lat_d = sat_inc(lat_q);
                    if (ap_done) begin
                        // lat_q counts cycles before this one; include the done cycle.
                        mod_lat_d = sat_inc(lat_q);
                        mod_run_d = sat_inc(mod_run_q);
                        if (!ap_continue)  mod_state_d = M_WAIT_CONT;
                        else if (ap_start) begin
                            mod_state_d = M_BUSY;
                            lat_d       = ONE;
                        end else           mod_state_d = M_IDLE;
                    end
                end
                M_WAIT_CONT: if (ap_continue) mod_state_d = M_IDLE;
                default:     mod_state_d = M_IDLE;
            endcase

            unique case (loop_state_q)
                L_IDLE: begin
                    if (loop_start) begin
                        loop_state_d = L_RUN;
                        trip_d       = '0;
                    end
                end
                L_RUN: begin
                    trip_d = trip_inc;
                    if (iter_end_evt) iter_total_d = sat_inc(iter_total_q);
                    if (stall_evt)    stall_d      = sat_inc(stall_q);
                    if (loop_done) begin
                        last_trip_d  = trip_inc;
                        loop_run_d   = sat_inc(loop_run_q);
                        loop_state_d = loop_continue ? L_IDLE : L_WAIT_CONT;
                    end
                end
                L_WAIT_CONT: if (loop_continue) loop_state_d = L_IDLE;
                default:     loop_state_d = L_IDLE;
            endcase
        end
    end

    // NOTE: registers only, no storage arrays, so every flop can take the reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (!reset) begin
            mod_state_q   <= M_IDLE;
            loop_state_q  <= L_IDLE;
            lat_q         <= '0;
            mod_run_q     <= '0;
            mod_ready_q   <= '0;
            mod_lat_q     <= '0;
            trip_q        <= '0;
            loop_run_q    <= '0;
            last_trip_q   <= '0;
            iter_total_q  <= '0;
            stall_q       <= '0;
            start_pulse_q <= 1'b0;
            end_pulse_q   <= 1'b0;
            quit_pulse_q  <= 1'b0;
            frozen_q      <= 1'b0;
        end else begin
            mod_state_q   <= mod_state_d;
            loop_state_q  <= loop_state_d;
            lat_q         <= lat_d;
            mod_run_q     <= mod_run_d;
            mod_ready_q   <= mod_ready_d;
            mod_lat_q     <= mod_lat_d;
            trip_q        <= trip_d;
            loop_run_q    <= loop_run_d;
            last_trip_q   <= last_trip_d;
            iter_total_q  <= iter_total_d;
            stall_q       <= stall_d;
            start_pulse_q <= start_pulse_d;
            end_pulse_q   <= end_pulse_d;
            quit_pulse_q  <= quit_pulse_d;
            frozen_q      <= frozen_d;
        end
    end

    assign mod_busy         = (mod_state_q == M_BUSY);
    assign mod_run_count    = mod_run_q;
    assign mod_ready_count  = mod_ready_q;
    assign mod_last_latency = mod_lat_q;
    assign loop_active      = in_run;
    assign loop_run_count   = loop_run_q;
    assign loop_last_trip   = last_trip_q;
    assign iter_start_pulse = start_pulse_q;
    assign iter_end_pulse   = end_pulse_q;
    assign quit_pulse       = quit_pulse_q;
    assign iter_total       = iter_total_q;
    assign stall_cycles     = stall_q;
    assign frozen           = frozen_q;

endmodule

// File: tb/tb_loop_activity_monitor.sv
// -----------------------------------------------------------------------------
// tb_loop_activity_monitor
//
// Directed self-checking bench for loop_activity_monitor (STATE_W=1, CNT_W=4 so
// that counter saturation is reachable). Inputs are driven 1 time unit after a
// rising edge and outputs are sampled at the same point, after the edge settles.
// -----------------------------------------------------------------------------
module tb_loop_activity_monitor;

    localparam int STATE_W = 1;
    localparam int CNT_W   = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               finish;
    logic               ap_start, ap_ready, ap_done, ap_continue;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic               iter_start_block, iter_end_block, quit_block;
    logic               iter_start_enable, iter_end_enable, quit_enable;
    logic               loop_start, loop_ready, loop_done, loop_continue;
    logic               quit_at_end;
    logic               mod_busy;
    logic [CNT_W-1:0]   mod_run_count, mod_ready_count, mod_last_latency;
    logic               loop_active;
    logic [CNT_W-1:0]   loop_run_count, loop_last_trip;
    logic               iter_start_pulse, iter_end_pulse, quit_pulse;
    logic [CNT_W-1:0]   iter_total, stall_cycles;
    logic               frozen;

    int total = 0;
    int bad   = 0;

    loop_activity_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .finish(finish),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .mod_busy(mod_busy), .mod_run_count(mod_run_count), .mod_ready_count(mod_ready_count),
        .mod_last_latency(mod_last_latency), .loop_active(loop_active),
        .loop_run_count(loop_run_count), .loop_last_trip(loop_last_trip),
        .iter_start_pulse(iter_start_pulse), .iter_end_pulse(iter_end_pulse), .quit_pulse(quit_pulse),
        .iter_total(iter_total), .stall_cycles(stall_cycles), .frozen(frozen)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_enables(input logic v);
        iter_start_enable = v;
        iter_end_enable   = v;
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            {finish, ap_start, ap_ready, ap_done, ap_continue} = 5'($urandom);
            {iter_start_block, iter_end_block, quit_block}     = 3'($urandom);
            {iter_start_enable, iter_end_enable, quit_enable}  = 3'($urandom);
            {loop_start, loop_ready, loop_done, loop_continue} = 4'($urandom);
            quit_at_end      = 1'($urandom);
            cur_state        = 1'($urandom);
            iter_start_state = 1'($urandom);
            iter_end_state   = 1'($urandom);
            quit_state       = 1'($urandom);
            step();
        end
        check("rst_mod_busy",     32'(mod_busy), 0);
        check("rst_mod_run",      32'(mod_run_count), 0);
        check("rst_mod_ready",    32'(mod_ready_count), 0);
        check("rst_mod_lat",      32'(mod_last_latency), 0);
        check("rst_loop_active",  32'(loop_active), 0);
        check("rst_loop_run",     32'(loop_run_count), 0);
        check("rst_loop_trip",    32'(loop_last_trip), 0);
        check("rst_pulses",       32'({iter_start_pulse, iter_end_pulse, quit_pulse}), 0);
        check("rst_iter_total",   32'(iter_total), 0);
        check("rst_stall",        32'(stall_cycles), 0);
        check("rst_frozen",       32'(frozen), 0);

        // quiet, well-defined inputs
        finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 1;
        quit_at_end = 1;
        cur_state = 1; iter_start_state = 1; iter_end_state = 1; quit_state = 1;
        reset = 1'b1;
        step();

        // ---------------- module run: start, done 5 cycles later ----------------
        ap_start = 1; step();
        ap_start = 0;
        check("m1_busy", 32'(mod_busy), 1);
        repeat (4) step();
        ap_done = 1; step();
        ap_done = 0;
        check("m1_latency", 32'(mod_last_latency), 6);
        check("m1_runs",    32'(mod_run_count), 1);
        check("m1_idle",    32'(mod_busy), 0);

        // ---------------- loop: 4 unblocked iterations ----------------
        loop_start = 1; step();
        loop_start = 0;
        check("l1_active", 32'(loop_active), 1);
        set_enables(1);
        repeat (3) step();
        check("l1_end_pulse",   32'(iter_end_pulse), 1);
        check("l1_start_pulse", 32'(iter_start_pulse), 1);
        quit_enable = 1; step();
        quit_enable = 0;
        check("l1_quit_pulse", 32'(quit_pulse), 1);
        set_enables(0);
        loop_done = 1; step();
        loop_done = 0;
        check("l1_trip",   32'(loop_last_trip), 4);
        check("l1_total",  32'(iter_total), 4);
        check("l1_runs",   32'(loop_run_count), 1);
        check("l1_idle",   32'(loop_active), 0);
        check("l1_pulse0", 32'(iter_end_pulse), 0);

        // ---------------- loop with 3-cycle stall ----------------
        loop_start = 1; step();
        loop_start = 0;
        set_enables(1);
        repeat (2) step();
        iter_start_block = 1; iter_end_block = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("l2_stall_pulses", 32'({iter_start_pulse, iter_end_pulse}), 0);
        end
        check("l2_stall_cycles", 32'(stall_cycles), 3);
        check("l2_total_mid",    32'(iter_total), 6);
        iter_start_block = 0; iter_end_block = 0;
        step();
        loop_done = 1; step();  // iteration end in the done cycle is credited
        loop_done = 0;
        set_enables(0);
        check("l2_trip",   32'(loop_last_trip), 4);
        check("l2_total",  32'(iter_total), 8);
        check("l2_runs",   32'(loop_run_count), 2);
        check("l2_stall",  32'(stall_cycles), 3);

        // ---------------- continue backpressure ----------------
        ap_start = 1; step();
        ap_start = 0; step();
        ap_done = 1; ap_continue = 0; step();
        ap_done = 0; ap_start = 1;
        check("bp_lat",  32'(mod_last_latency), 3);
        check("bp_runs", 32'(mod_run_count), 2);
        step();
        check("bp_wait1", 32'(mod_busy), 0);
        step();
        check("bp_wait2", 32'(mod_busy), 0);
        check("bp_runs_hold", 32'(mod_run_count), 2);
        ap_continue = 1; step();
        check("bp_to_idle", 32'(mod_busy), 0);
        step();
        ap_start = 0;
        check("bp_restart", 32'(mod_busy), 1);
        ap_done = 1; step();
        ap_done = 0;
        check("bp_lat2",  32'(mod_last_latency), 2);
        check("bp_runs2", 32'(mod_run_count), 3);

        // start and done together from IDLE
        ap_start = 1; ap_done = 1; step();
        ap_start = 0; ap_done = 0;
        check("sd_lat",  32'(mod_last_latency), 1);
        check("sd_runs", 32'(mod_run_count), 4);
        check("sd_idle", 32'(mod_busy), 0);

        // ---------------- saturation of ap_ready counter ----------------
        ap_ready = 1;
        repeat (14) step();
        check("sat_14", 32'(mod_ready_count), 14);
        repeat (3) step();
        ap_ready = 0;
        check("sat_hold", 32'(mod_ready_count), 15);

        // ---------------- finish mid-run ----------------
        loop_start = 1; step();
        loop_start = 0;
        set_enables(1); step();
        check("f_pre_total", 32'(iter_total), 9);
        check("f_pre_pulse", 32'(iter_end_pulse), 1);
        finish = 1; step();
        finish = 0;
        check("f_frozen",  32'(frozen), 1);
        check("f_total",   32'(iter_total), 9);
        check("f_pulses",  32'({iter_start_pulse, iter_end_pulse, quit_pulse}), 0);
        check("f_active",  32'(loop_active), 1);
        loop_done = 1; ap_start = 1; ap_done = 1;
        repeat (2) step();
        loop_done = 0; ap_start = 0; ap_done = 0;
        check("f_sticky",    32'(frozen), 1);
        check("f_total2",    32'(iter_total), 9);
        check("f_loop_runs", 32'(loop_run_count), 2);
        check("f_mod_runs",  32'(mod_run_count), 4);
        check("f_pulses2",   32'(iter_end_pulse), 0);
        reset = 0; step();
        reset = 1;
        check("fr_frozen", 32'(frozen), 0);
        check("fr_total",  32'(iter_total), 0);
        check("fr_active", 32'(loop_active), 0);
        check("fr_runs",   32'(mod_run_count), 0);
        set_enables(0);
        step();
        check("fr_pulse_after", 32'(iter_end_pulse), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_activity_monitor.md
Name: loop_activity_monitor

Overview:
- Synthesizable, passive performance monitor for one HLS block. Never drives the monitored design.
- Watches the block's module handshake (ap_start/ap_ready/ap_done/ap_continue).
- Watches one pipelined loop inside the block through its FSM state, stage block flags and stage enables.
- Produces run, iteration, stall and latency counters plus event pulses, readable by a simulation or debug harness.

Parameters:
- STATE_W, 2, width of the loop FSM state vector (one-hot state encoding).
- CNT_W, 32, width of every counter output; all counters saturate at 2^CNT_W-1.

Ports:
- clock  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- finish  in  1  end of simulation or measurement; freezes all state.
- ap_start  in  1  module start.
- ap_ready  in  1  module ready.
- ap_done  in  1  module done.
- ap_continue  in  1  module continue (tie 1 if unused).
- cur_state  in  STATE_W  loop FSM current state.
- iter_start_state, iter_end_state, quit_state  in  STATE_W  FSM state constants.
- iter_start_block, iter_end_block, quit_block  in  1  stage subdone block flags (1 = stalled).
- iter_start_enable, iter_end_enable, quit_enable  in  1  pipeline stage enable regs.
- loop_start, loop_ready, loop_done, loop_continue  in  1  loop handshake.
- quit_at_end  in  1  1 = loop exit is evaluated in the iteration-end stage; 0 = in quit_state.
- mod_busy  out  1  module run in progress.
- mod_run_count  out  CNT_W  completed module runs.
- mod_ready_count  out  CNT_W  ap_ready pulses.
- mod_last_latency  out  CNT_W  cycles from start to done of the last module run.
- loop_active  out  1  loop run in progress.
- loop_run_count  out  CNT_W  completed loop runs.
- loop_last_trip  out  CNT_W  completed iterations in the last loop run.
- iter_start_pulse, iter_end_pulse, quit_pulse  out  1  one-cycle event strobes.
- iter_total  out  CNT_W  completed iterations over all runs.
- stall_cycles  out  CNT_W  cycles the loop sat in iter_start_state with iter_start_block=1.
- frozen  out  1  finish has been seen.

Behaviour:
- Reset (reset=0 at a rising edge):
  - Every output register goes to 0; both state machines go to IDLE; frozen=0.
  - Reset applied mid-run aborts that run with no partial latching.
- Event qualification (combinational, only while loop_active=1):
  - iter_start_evt = (cur_state==iter_start_state) & ~iter_start_block & iter_start_enable.
  - iter_end_evt = (cur_state==iter_end_state) & ~iter_end_block & iter_end_enable.
  - quit_evt = (cur_state==quit_state) & ~quit_block & quit_enable.
  - The three pulse outputs are registered copies of these events, so each appears 1 cycle after the qualifying cycle.
- Module FSM (states IDLE, BUSY, WAIT_CONT):
  - IDLE -> BUSY on ap_start. Latency counter is set to 1 in that cycle.
  - BUSY increments latency every cycle.
  - BUSY on ap_done: latch mod_last_latency = count, increment mod_run_count.
    - If ap_continue=1: go to IDLE, or straight back to BUSY with latency=1 if ap_start=1 in the same cycle.
    - If ap_continue=0: go to WAIT_CONT.
  - WAIT_CONT -> IDLE on ap_continue.
  - ap_start and ap_done in the same cycle as IDLE->BUSY gives latency 1.
  - mod_ready_count increments on every ap_ready=1 cycle, in any state.
  - mod_busy = (state==BUSY).
- Loop FSM (states IDLE, RUN, WAIT_CONT):
  - IDLE -> RUN on loop_start. Trip counter cleared.
  - In RUN, each iter_end_evt increments both the trip counter and iter_total.
  - In RUN, stall_cycles increments on cur_state==iter_start_state & iter_start_block.
  - With quit_at_end=1, quit_evt is informational only.
  - With quit_at_end=0, after a quit_evt further iter_start_evt pulses are still strobed but no new iteration is credited; only iter_end_evt counts.
  - RUN on loop_done: latch loop_last_trip (including any iter_end_evt in the same cycle), increment loop_run_count, then go to IDLE if loop_continue else WAIT_CONT.
  - WAIT_CONT -> IDLE on loop_continue.
  - loop_active = (state==RUN).
- Saturation: no counter wraps; each holds at all-ones.
- finish=1 at a rising edge sets frozen=1 (sticky until reset). While frozen, all counters, FSMs and pulses hold; pulses are forced to 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> every output 0.
- Module run: ap_start for 1 cycle, ap_done 5 cycles later, ap_continue=1 -> mod_last_latency=6, mod_run_count=1, mod_busy low the next cycle.
- Pipelined loop, STATE_W=1, quit_at_end=1: loop_start, 4 unblocked iterations with iter_end_enable, loop_done -> loop_last_trip=4, iter_total=4, loop_run_count=1.
- Stalls: same loop with iter_start_block=1 for 3 cycles mid-run -> stall_cycles=3, trip count unchanged, no pulses during the stall.
- Continue backpressure: ap_continue=0 at done for 2 cycles, with ap_start asserted meanwhile -> remains in WAIT_CONT, new run not started until continue.
- Finish: assert finish mid-run with iter_end_evt pending -> frozen=1, counters hold, pulses 0; reset clears frozen.
